// File: rtl/agc_loop_sequencer.sv
// agc_loop_sequencer
//   Wishbone master that walks the enabled AGC channels, runs one measurement
//   window per channel, reads the accumulators and current settings, steps
//   scale/offset toward the target window and writes them back with apply.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, async active-high reset
//   start_i                 pulse, begins a sweep when idle
//   continuous_i            restart the sweep immediately after a clean finish
//   chan_mask_i             channels to service, sampled at sweep start
//   target_lo_i/hi_i        square-accumulator window
//   scale_step_i            scale increment/decrement
//   offset_step_i           offset increment/decrement
//   deadband_i              allowed |gt-lt| before offset moves
//   busy_o, done_o, err_o   sweep status (done_o is a 1-cycle pulse, err_o sticky)
//   cur_chan_o              channel being serviced
//   m_wb_*                  Wishbone master port (byte addresses, chan*32+reg)
module agc_loop_sequencer #(
  parameter  int NCHAN       = 8,
  parameter  int POLL_LIMIT  = 65535,
  parameter  int ACK_TIMEOUT = 255,
  localparam int CW          = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW          = CW + 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic [NCHAN-1:0] chan_mask_i,
  input  logic [24:0]      target_lo_i,
  input  logic [24:0]      target_hi_i,
  input  logic [7:0]       scale_step_i,
  input  logic [7:0]       offset_step_i,
  input  logic [20:0]      deadband_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CW-1:0]    cur_chan_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  output logic             m_wb_we_o,
  output logic [AW-1:0]    m_wb_adr_o,
  output logic [31:0]      m_wb_dat_o,
  output logic [3:0]       m_wb_sel_o,
  input  logic [31:0]      m_wb_dat_i,
  input  logic             m_wb_ack_i,
  input  logic             m_wb_err_i
);

  localparam int PCW = (POLL_LIMIT  > 1) ? $clog2(POLL_LIMIT)    : 1;
  localparam int ACW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT+1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TICK, S_POLL, S_RD_SQ, S_RD_GT, S_RD_LT, S_RD_SCALE, S_RD_OFF,
    S_CALC, S_WR_SCALE, S_WR_OFF, S_APPLY, S_NEXT
  } state_t;

  // per-state bus operation, relative to the channel base
  typedef struct packed {
    logic        we;
    logic [4:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_op_t;

  // registered master request
  typedef struct packed {
    logic          cyc;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } wb_req_t;

  state_t           state_q, state_d;
  wb_req_t          req_q, req_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [CW-1:0]    cur_q, cur_d;
  logic [PCW-1:0]   poll_q, poll_d;
  logic [ACW-1:0]   ack_q, ack_d;
  logic [24:0]      sq_q, sq_d;
  logic [20:0]      gt_q, gt_d, lt_q, lt_d;
  logic [16:0]      scale_q, scale_d;
  logic [15:0]      off_q, off_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  bus_op_t          op;
  logic             op_vld;
  logic             found;
  logic [CW-1:0]    idx;
  logic             fail, sweep_end;

  // read data bits above the widest register field carry nothing we use
  logic unused_dat;
  assign unused_dat = ^m_wb_dat_i[31:25];

  // ---------------------------------------------------------------- datapath
  logic [17:0]        sc_sum;
  logic [16:0]        sc_up, sc_dn;
  logic [21:0]        gt22, lt22, db22;
  logic signed [16:0] off_sx, step_sx, off_inc, off_dec;
  logic [15:0]        off_up, off_dn;

  assign sc_sum  = {1'b0, scale_q} + {10'b0, scale_step_i};
  assign sc_up   = sc_sum[17] ? 17'h1FFFF : sc_sum[16:0];
  assign sc_dn   = (scale_q > {9'b0, scale_step_i}) ? scale_q - {9'b0, scale_step_i} : 17'h0;

  // one extra bit keeps lt+deadband from wrapping
  assign gt22    = {1'b0, gt_q};
  assign lt22    = {1'b0, lt_q};
  assign db22    = {1'b0, deadband_i};

  // 17-bit signed result; bits [16:15] disagree exactly when 16 bits overflow
  assign off_sx  = $signed({off_q[15], off_q});
  assign step_sx = $signed({9'b0, offset_step_i});
  assign off_inc = off_sx + step_sx;
  assign off_dec = off_sx - step_sx;
  assign off_up  = (off_inc[16] != off_inc[15]) ? 16'h7FFF : off_inc[15:0];
  assign off_dn  = (off_dec[16] != off_dec[15]) ? 16'h8000 : off_dec[15:0];

  // lowest pending channel
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NCHAN-1; i >= 0; i--) begin
      if (mask_q[i]) begin
        found = 1'b1;
        idx   = CW'(i);
      end
    end
  end

  // bus operation for each bus state
  always_comb begin
    op_vld  = 1'b1;
    op.we   = 1'b0;
    op.off  = 5'h00;
    op.dat  = 32'h0;
    op.sel  = 4'hF;
    case (state_q)
      S_TICK:     begin op.we = 1'b1; op.dat = 32'h1; op.sel = 4'h1; end
      S_POLL:     op.off = 5'h00;
      S_RD_SQ:    op.off = 5'h04;
      S_RD_GT:    op.off = 5'h08;
      S_RD_LT:    op.off = 5'h0C;
      S_RD_SCALE: op.off = 5'h10;
      S_RD_OFF:   op.off = 5'h14;
      S_WR_SCALE: begin op.we = 1'b1; op.off = 5'h10; op.dat = {15'b0, scale_q}; op.sel = 4'h7; end
      S_WR_OFF:   begin op.we = 1'b1; op.off = 5'h14; op.dat = {16'b0, off_q};   op.sel = 4'h3; end
      S_APPLY:    begin op.we = 1'b1; op.dat = 32'h700; op.sel = 4'h2; end
      default:    op_vld = 1'b0;
    endcase
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mask_d    = mask_q;
    cur_d     = cur_q;
    poll_d    = poll_q;
    ack_d     = ack_q;
    sq_d      = sq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    scale_d   = scale_q;
    off_d     = off_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fail      = 1'b0;
    sweep_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d  = chan_mask_i;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (found) begin
          cur_d   = idx;
          mask_d  = mask_q & ~(NCHAN'(1) << idx);
          poll_d  = '0;
          state_d = S_TICK;
        end else begin
          sweep_end = 1'b1;
        end
      end

      S_CALC: begin
        if (sq_q > target_hi_i)      scale_d = sc_dn;
        else if (sq_q < target_lo_i) scale_d = sc_up;
        if (gt22 > lt22 + db22)      off_d = off_dn;
        else if (lt22 > gt22 + db22) off_d = off_up;
        state_d = S_WR_SCALE;
      end

      default: begin
        if (op_vld) begin
          if (!req_q.cyc) begin
            // cyc was low for this cycle, which provides the inter-transaction gap
            req_d.cyc = 1'b1;
            req_d.we  = op.we;
            req_d.adr = {cur_q, op.off};
            req_d.dat = op.dat;
            req_d.sel = op.sel;
            ack_d     = '0;
          end else if (m_wb_err_i) begin
            fail = 1'b1;
          end else if (m_wb_ack_i) begin
            req_d.cyc = 1'b0;
            case (state_q)
              S_TICK:     state_d = S_POLL;
              S_POLL: begin
                if (m_wb_dat_i[1])                     state_d = S_RD_SQ;
                else if (poll_q == PCW'(POLL_LIMIT-1)) fail    = 1'b1;
                else                                   poll_d  = poll_q + 1'b1;
              end
              S_RD_SQ:    begin sq_d    = m_wb_dat_i[24:0]; state_d = S_RD_GT;    end
              S_RD_GT:    begin gt_d    = m_wb_dat_i[20:0]; state_d = S_RD_LT;    end
              S_RD_LT:    begin lt_d    = m_wb_dat_i[20:0]; state_d = S_RD_SCALE; end
              S_RD_SCALE: begin scale_d = m_wb_dat_i[16:0]; state_d = S_RD_OFF;   end
              S_RD_OFF:   begin off_d   = m_wb_dat_i[15:0]; state_d = S_CALC;     end
              S_WR_SCALE: state_d = S_WR_OFF;
              S_WR_OFF:   state_d = S_APPLY;
              S_APPLY:    state_d = S_NEXT;
              default:    state_d = S_IDLE;
            endcase
          end else if (ack_q == ACW'(ACK_TIMEOUT)) begin
            // cyc has now been high for ACK_TIMEOUT+1 cycles
            fail = 1'b1;
          end else begin
            ack_d = ack_q + 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (sweep_end) begin
      done_d = 1'b1;
      if (continuous_i) begin
        mask_d  = chan_mask_i;
        state_d = S_NEXT;
      end else begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end

    // errors end the sweep and never auto-restart
    if (fail) begin
      req_d.cyc = 1'b0;
      err_d     = 1'b1;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = S_IDLE;
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      poll_q  <= '0;
      ack_q   <= '0;
      sq_q    <= '0;
      gt_q    <= '0;
      lt_q    <= '0;
      scale_q <= '0;
      off_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      poll_q  <= poll_d;
      ack_q   <= ack_d;
      sq_q    <= sq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      scale_q <= scale_d;
      off_q   <= off_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cur_chan_o = cur_q;
  assign m_wb_cyc_o = req_q.cyc;
  assign m_wb_stb_o = req_q.cyc;
  assign m_wb_we_o  = req_q.we;
  assign m_wb_adr_o = req_q.adr;
  assign m_wb_dat_o = req_q.dat;
  assign m_wb_sel_o = req_q.sel;

endmodule

// File: tb/tb_agc_loop_sequencer.sv
module tb_agc_loop_sequencer;
  localparam int NCHAN = 8;
  localparam int PL    = 12;
  localparam int AT    = 15;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 0, cont = 0;
  logic [NCHAN-1:0] mask = '0;
  logic [24:0]      tlo = '0, thi = '0;
  logic [7:0]       sstep = '0, ostep = '0;
  logic [20:0]      dband = '0;
  logic             busy, done, err;
  logic [2:0]       cur;
  logic             cyc, stb, we;
  logic [AW-1:0]    adr;
  logic [31:0]      dat_o;
  logic [3:0]       sel;
  logic [31:0]      rdat = '0;
  logic             ack = 0;
  logic             berr = 0;

  agc_loop_sequencer #(.NCHAN(NCHAN), .POLL_LIMIT(PL), .ACK_TIMEOUT(AT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .continuous_i(cont),
    .chan_mask_i(mask), .target_lo_i(tlo), .target_hi_i(thi),
    .scale_step_i(sstep), .offset_step_i(ostep), .deadband_i(dband),
    .busy_o(busy), .done_o(done), .err_o(err), .cur_chan_o(cur),
    .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_we_o(we), .m_wb_adr_o(adr),
    .m_wb_dat_o(dat_o), .m_wb_sel_o(sel), .m_wb_dat_i(rdat),
    .m_wb_ack_i(ack), .m_wb_err_i(berr)
  );

  // ---------------------------------------------------------- slave model
  typedef logic [44:0] ent_t;          // {we, adr, dat, sel}
  ent_t        log_q[$];
  ent_t        exp_q[$];
  logic [2:0]  chan_q[$];
  logic [31:0] sq_m[NCHAN], gt_m[NCHAN], lt_m[NCHAN], sc_m[NCHAN], of_m[NCHAN];
  int          pc[NCHAN];
  int          done_after = 0;
  bit          never_ack  = 0;
  int          wcnt = 0;

  always @(posedge clk) begin
    ack <= 1'b0;
    if (cyc && stb && !ack && !never_ack) begin
      if (wcnt == 2) begin
        wcnt <= 0;
        ack  <= 1'b1;
        log_q.push_back({we, adr, dat_o, sel});
        if (we) begin
          if (adr[4:0] == 5'h00 && dat_o[0]) begin
            pc[adr[7:5]] <= 0;
            chan_q.push_back(cur);
          end
        end else begin
          case (adr[4:0])
            5'h00: begin
              pc[adr[7:5]] <= pc[adr[7:5]] + 1;
              rdat <= {30'b0, (done_after != 0 && pc[adr[7:5]] + 1 >= done_after), 1'b0};
            end
            5'h04:   rdat <= sq_m[adr[7:5]];
            5'h08:   rdat <= gt_m[adr[7:5]];
            5'h0C:   rdat <= lt_m[adr[7:5]];
            5'h10:   rdat <= sc_m[adr[7:5]];
            5'h14:   rdat <= of_m[adr[7:5]];
            default: rdat <= 32'h0;
          endcase
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!cyc) begin
      wcnt <= 0;
    end
  end

  // activity monitors, sampled mid-cycle
  int done_cnt = 0, cyc_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (cyc)  cyc_cnt  <= cyc_cnt + 1;
  end

  // ------------------------------------------------------------- checking
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t e(input bit w, input int a, input int d, input int s);
    return {w, AW'(a), 32'(d), 4'(s)};
  endfunction

  task automatic exp_chan(input int ch, input int polls, input int sc, input int of);
    int b;
    b = ch * 32;
    exp_q.push_back(e(1, b, 1, 1));
    repeat (polls) exp_q.push_back(e(0, b, 0, 'hF));
    exp_q.push_back(e(0, b + 'h04, 0, 'hF));
    exp_q.push_back(e(0, b + 'h08, 0, 'hF));
    exp_q.push_back(e(0, b + 'h0C, 0, 'hF));
    exp_q.push_back(e(0, b + 'h10, 0, 'hF));
    exp_q.push_back(e(0, b + 'h14, 0, 'hF));
    exp_q.push_back(e(1, b + 'h10, sc, 7));
    exp_q.push_back(e(1, b + 'h14, of, 3));
    exp_q.push_back(e(1, b, 'h700, 2));
  endtask

  task automatic cmp_log(input string tag);
    int n;
    chk({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_txn%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_start(input logic [NCHAN-1:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < max), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, c0, n;

    for (int c = 0; c < NCHAN; c++) begin
      sq_m[c] = 0; gt_m[c] = 0; lt_m[c] = 0; sc_m[c] = 0; of_m[c] = 0; pc[c] = 0;
    end
    sq_m[0] = 32'h200000; gt_m[0] = 1000; lt_m[0] = 100;  sc_m[0] = 32'h00003; of_m[0] = 32'h8005;
    sq_m[2] = 32'h000100; gt_m[2] = 500;  lt_m[2] = 500;  sc_m[2] = 32'h1FFFC; of_m[2] = 32'h1234;
    sq_m[5] = 32'h100000; gt_m[5] = 150;  lt_m[5] = 100;  sc_m[5] = 32'h0ABCD; of_m[5] = 32'h0042;
    sq_m[7] = 32'h050000; gt_m[7] = 0;    lt_m[7] = 2000; sc_m[7] = 32'h00100; of_m[7] = 32'h7FFA;
    tlo = 25'h010000; thi = 25'h100000; sstep = 8; ostep = 10; dband = 50;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cyc, stb, we, busy, done, err}, 6'b0);
    chk("rst_cur", cur, 3'd0);
    chk("rst_adr", adr, 8'h0);
    rst = 1'b0;

    // sweep over ch0 and ch2: scale saturates low/high, offset saturates low / holds
    done_after = 10;
    d0 = done_cnt;
    do_start(8'h05);
    wait_done(2000, "s1_done");
    chk("s1_err", err, 1'b0);
    chk("s1_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("s1_done_pulses", 64'(done_cnt - d0), 64'd1);
    exp_chan(0, 10, 'h00000, 'h8000);
    exp_chan(2, 10, 'h1FFFF, 'h1234);
    cmp_log("s1");
    chk("s1_nchan", 64'(chan_q.size()), 64'd2);
    if (chan_q.size() == 2) begin
      chk("s1_cur0", chan_q[0], 3'd0);
      chk("s1_cur1", chan_q[1], 3'd2);
    end
    chan_q.delete();

    // ch5 (sq at hi, gt at lt+deadband: both hold) and ch7 (offset saturates high);
    // a second start mid-sweep must be ignored
    d0 = done_cnt;
    do_start(8'hA0);
    repeat (5) @(negedge clk);
    mask = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, "s2_done");
    chk("s2_err", err, 1'b0);
    repeat (3) @(negedge clk);
    chk("s2_done_pulses", 64'(done_cnt - d0), 64'd1);
    exp_chan(5, 10, 'h0ABCD, 'h0042);
    exp_chan(7, 10, 'h00100, 'h7FFF);
    cmp_log("s2");
    chan_q.delete();

    // ack timeout
    never_ack = 1;
    c0 = cyc_cnt;
    d0 = done_cnt;
    do_start(8'h01);
    wait_done(300, "to_done");
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    chk("to_cyc_cycles", 64'(cyc_cnt - c0), 64'(AT + 1));
    chk("to_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("to_log", 64'(log_q.size()), 64'd0);
    never_ack = 0;
    log_q.delete();
    chan_q.delete();

    // poll limit; the accepted start clears the sticky error
    done_after = 0;
    chk("pl_err_sticky", err, 1'b1);
    do_start(8'h02);
    chk("pl_err_clr", err, 1'b0);
    wait_done(2000, "pl_done");
    chk("pl_err", err, 1'b1);
    exp_q.push_back(e(1, 'h20, 1, 1));
    repeat (PL) exp_q.push_back(e(0, 'h20, 0, 'hF));
    cmp_log("pl");
    chan_q.delete();

    // reset during RD_GT
    done_after = 1;
    do_start(8'h01);
    n = 0;
    while (!(cyc && !we && adr == 8'h08) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rg_reach", 64'(n < 500), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rg_bus", {cyc, stb, busy}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    chan_q.delete();

    // empty mask: done one cycle after start, no bus activity
    c0 = cyc_cnt;
    do_start(8'h00);
    chk("m0_first", {busy, done}, 2'b10);
    @(negedge clk);
    chk("m0_done", {busy, done}, 2'b01);
    repeat (3) @(negedge clk);
    chk("m0_nocyc", 64'(cyc_cnt - c0), 64'd0);

    // continuous: first sweep end restarts with busy held, second ends normally
    cont = 1'b1;
    do_start(8'h01);
    wait_done(1000, "ct_done1");
    chk("ct_busy_held", busy, 1'b1);
    cont = 1'b0;
    @(negedge clk);
    wait_done(1000, "ct_done2");
    @(negedge clk);
    chk("ct_busy_end", busy, 1'b0);
    exp_chan(0, 1, 'h00000, 'h8000);
    exp_chan(0, 1, 'h00000, 'h8000);
    cmp_log("ct");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
